// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port main memory between the I-cache refill path and the
// D-cache refill/write-back path. Each granted line request is expanded into
// LINE_WORDS word accesses. Refill words come back one beat at a time through
// a shared registered rdata. The block also drives the pipeline-wide stall.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   i_req/i_addr        : I-side line request (held until i_done), miss address
//   i_rvalid/i_done     : I-side refill beat valid, one-cycle completion pulse
//   d_req/d_we/d_addr   : D-side line request, direction (1 = write-back), address
//   d_wdata             : D-side write-back word for index `beat`
//   d_rvalid/d_done     : D-side refill beat valid, one-cycle completion pulse
//   rdata               : registered refill word, shared by both sides
//   beat                : issue beat index, or the index of rdata while *_rvalid
//   owner, busy         : current burst owner (0 = I, 1 = D), burst in progress
//   mem_*               : memory port (mem_ack accepts; read data same cycle)
//   stall               : pipeline stall request
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    localparam int BW        = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [BW-1:0]     beat,
    output logic              owner,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
        $error("mem_arbiter: LINE_WORDS must be a power of two >= 2");
    end

    // Byte offset bits inside one line; cleared to form the line base.
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    // Everything captured at grant time; later changes on the request side
    // are deliberately ignored until the burst finishes.
    typedef struct packed {
        logic              owner;
        logic              we;
        logic [ADDR_W-1:0] base;
    } grant_t;

    state_t            state, state_nx;
    grant_t            grant_q, grant_nx;
    logic [BW-1:0]     cnt_q, cnt_nx;
    logic              last_owner, last_nx;
    logic              rd_fire;
    logic              rv_q;
    logic [BW-1:0]     rv_beat;

    // ------------------------------------------------------------------
    // Next-state and memory-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        cnt_nx   = cnt_q;
        last_nx  = last_owner;
        rd_fire  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // On conflict the side that did not win last time goes.
                    grant_nx.owner = (i_req && d_req) ? ~last_owner : d_req;
                    grant_nx.we    = grant_nx.owner & d_we;
                    grant_nx.base  = (grant_nx.owner ? d_addr : i_addr) & ~LINE_MASK;
                    cnt_nx         = '0;
                    state_nx       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mem_req  = 1'b1;
                mem_we   = grant_q.we;
                // Plain ADDR_W-bit add: wraps modulo 2^ADDR_W at the top.
                mem_addr = grant_q.base + (ADDR_W'(cnt_q) << 2);
                if (mem_ack) begin
                    rd_fire = ~grant_q.we;
                    if (cnt_q == LAST_BEAT) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                i_done   = ~grant_q.owner;
                d_done   = grant_q.owner;
                last_nx  = grant_q.owner;
                state_nx = S_IDLE;
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            grant_q    <= '0;
            cnt_q      <= '0;
            last_owner <= 1'b0;
            rv_q       <= 1'b0;
            rv_beat    <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            grant_q    <= grant_nx;
            cnt_q      <= cnt_nx;
            last_owner <= last_nx;
            rv_q       <= rd_fire;
            if (rd_fire) begin
                rdata   <= mem_rdata;
                rv_beat <= cnt_q;
            end
        end
    end

    // The owner cannot change while a refill word is pending: the last
    // beat's rvalid lands in DONE, before the next grant.
    assign i_rvalid  = rv_q & ~grant_q.owner;
    assign d_rvalid  = rv_q &  grant_q.owner;

    // While a refill word is presented, beat names that word; otherwise it
    // tracks the beat being issued.
    assign beat      = rv_q ? rv_beat : cnt_q;

    assign owner     = grant_q.owner;
    assign busy      = (state != S_IDLE);
    assign mem_wdata = d_wdata;
    assign stall     = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int LW = 4;

    logic        clk = 0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata, rdata, mem_addr, mem_wdata;
    logic        i_rvalid, i_done, d_rvalid, d_done, owner, busy, mem_req, mem_we, stall;
    logic [1:0]  beat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory returns its own address as data; D-side supplies 0xA0+beat.
    assign mem_rdata = mem_addr;
    assign d_wdata   = 32'hA0 + 32'(beat);

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_done(d_done),
        .rdata(rdata), .beat(beat), .owner(owner), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 issuing beat m_k, 2 completion.
    // Pending refill words sit in a one-entry slot for the next cycle.
    // ------------------------------------------------------------------
    int          ph = 0;
    int          m_k = 0;
    bit          m_own, m_we, m_last = 0;
    logic [31:0] m_base;
    bit          rv_pend = 0, rv_own;
    logic [31:0] rv_data;
    int          rv_beat;
    bit          glog[$];
    bit          e_idone, e_ddone;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_i_rvalid", i_rvalid, 0);
                chk("rst_d_rvalid", d_rvalid, 0);
                chk("rst_i_done", i_done, 0);
                chk("rst_d_done", d_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_owner", owner, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_mem_addr", mem_addr, 0);
                ph = 0; m_k = 0; m_last = 0; rv_pend = 0;
            end else begin
                e_idone = (ph == 2) && !m_own;
                e_ddone = (ph == 2) && m_own;
                chk("mem_req", mem_req, ph == 1);
                chk("busy", busy, ph != 0);
                chk("i_done", i_done, e_idone);
                chk("d_done", d_done, e_ddone);
                chk("i_rvalid", i_rvalid, rv_pend && !rv_own);
                chk("d_rvalid", d_rvalid, rv_pend && rv_own);
                chk("mem_we", mem_we, (ph == 1) && m_we);
                chk("stall", stall, (i_req && !e_idone) || (d_req && !e_ddone));
                if (rv_pend) begin
                    chk("rdata", rdata, rv_data);
                    chk("rv_beat", beat, rv_beat);
                end else if (ph == 1) begin
                    chk("beat", beat, m_k);
                end
                if (ph != 0) chk("owner", owner, m_own);
                if (ph == 1) begin
                    chk("mem_addr", mem_addr, m_base + 32'(4 * m_k));
                    chk("mem_wdata", mem_wdata, d_wdata);
                end
                // advance to what the next cycle must show
                rv_pend = 0;
                case (ph)
                    0: if (i_req || d_req) begin
                        m_own  = (i_req && d_req) ? !m_last : d_req;
                        m_we   = m_own ? d_we : 1'b0;
                        m_base = (m_own ? d_addr : i_addr) & ~32'(LW * 4 - 1);
                        m_k    = 0;
                        ph     = 1;
                        glog.push_back(m_own);
                    end
                    1: if (mem_ack) begin
                        if (!m_we) begin
                            rv_pend = 1; rv_own = m_own; rv_data = mem_rdata; rv_beat = m_k;
                        end
                        if (m_k == LW - 1) ph = 2;
                        else m_k++;
                    end
                    default: begin
                        m_last = m_own;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int ack_tab[7] = '{1, 0, 0, 1, 1, 1, 1};
    int off_tab[6] = '{0, 4, 4, 4, 8, 12};

    initial begin
        int n;
        reset = 0; i_req = 1; d_req = 1; d_we = 0;
        i_addr = 32'h100; d_addr = 32'h200; mem_ack = 1;

        // Reset held with both requests high
        tick(3);
        @(negedge clk);
        chk("lit_rst_mem_req", mem_req, 0);
        chk("lit_rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1;

        // Continuous conflict: four bursts must alternate D, I, D, I
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (i_done || d_done) n++;
        end
        chk("conflict_dones", n, 4);
        @(posedge clk); #1;
        i_req = 0; d_req = 0;
        chk("grant_count", glog.size() >= 4, 1);
        if (glog.size() >= 4) begin
            chk("grant0_D", glog[0], 1);
            chk("grant1_I", glog[1], 0);
            chk("grant2_D", glog[2], 1);
            chk("grant3_I", glog[3], 0);
        end
        tick(2);

        // I refill from 0x1234 with mem_ack tied high
        i_addr = 32'h0000_1234; i_req = 1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c <= 4) chk("i_mem_addr", mem_addr, 32'h1230 + 32'(4 * (c - 1)));
            chk("i_rvalid_lit", i_rvalid, c >= 2);
            if (c >= 2) chk("i_rdata_lit", rdata, 32'h1230 + 32'(4 * (c - 2)));
            chk("i_done_lit", i_done, c == 5);
        end
        @(posedge clk); #1;
        i_req = 0;
        tick(2);

        // D write-back with two wait cycles on beat 1
        d_addr = 32'h8000_0010; d_we = 1; d_req = 1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            mem_ack = ack_tab[c - 1][0];
            @(negedge clk);
            if (c <= 6) begin
                chk("wb_mem_addr", mem_addr, 32'h8000_0010 + 32'(off_tab[c - 1]));
                chk("wb_mem_wdata", mem_wdata, 32'hA0 + 32'(off_tab[c - 1] / 4));
                chk("wb_mem_we", mem_we, 1);
            end
            chk("wb_no_rvalid", d_rvalid, 0);
            chk("wb_d_done", d_done, c == 7);
        end
        chk("wb_stall_at_done", stall, 0);
        @(posedge clk); #1;
        d_req = 0; d_we = 0; mem_ack = 1;
        tick(2);

        // Refill at the very top of the address space
        d_addr = 32'hFFFF_FFFC; d_req = 1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c <= 4) chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFF0 + 32'(4 * (c - 1)));
            chk("wrap_d_done", d_done, c == 5);
        end
        @(posedge clk); #1;
        d_req = 0;
        tick(2);

        // Asynchronous reset in the middle of beat 2 of an I refill
        i_addr = 32'h40; i_req = 1;
        tick(3);
        chk("ar_beat2_addr", mem_addr, 32'h48);
        chk("ar_beat2_req", mem_req, 1);
        #1 reset = 0;
        #1;
        chk("ar_mem_req_drop", mem_req, 0);
        chk("ar_busy_drop", busy, 0);
        i_req = 0;
        @(posedge clk); #1;
        reset = 1;
        tick(1);
        i_req = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_restart_addr", mem_addr, 32'h40);
        chk("ar_restart_beat", beat, 0);
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (i_done) n = 1;
        end
        chk("ar_done_seen", n, 1);
        @(posedge clk); #1;
        i_req = 0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port main memory between the instruction-cache refill path and the data-cache refill/write-back path of the pipelined RISC-V core. It takes line-level requests from each side, expands each into a sequence of word accesses on the memory port, and returns refill data beat by beat. It also produces the pipeline-wide `stall` consumed by the datapath's hazard unit.

## Interface
Parameters:
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 32: byte address width.
- `LINE_WORDS`, default 4: words per cache line. Must be a power of two, ≥2. `BW = log2(LINE_WORDS)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `i_req` in 1: I-side line request, held high until `i_done`.
- `i_addr` in ADDR_W: I-side miss address; the line base is taken from it.
- `i_rvalid` out 1: I-side refill beat valid.
- `i_done` out 1: one-cycle I-side completion pulse.
- `d_req` in 1: D-side line request, held high until `d_done`.
- `d_we` in 1: D-side direction, 1 = line write-back, 0 = refill.
- `d_addr` in ADDR_W: D-side miss address.
- `d_wdata` in DATA_W: write-back word for beat `beat`.
- `d_rvalid` out 1: D-side refill beat valid.
- `d_done` out 1: one-cycle D-side completion pulse.
- `rdata` out DATA_W: registered refill word, shared by both sides.
- `beat` out BW: during ISSUE, the current beat index. With `*_rvalid`, the index of `rdata`.
- `owner` out 1: 0 = I-side, 1 = D-side. Meaningful when `busy`.
- `busy` out 1: a burst is in progress (ISSUE or DONE).
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory word address (byte address).
- `mem_wdata` out DATA_W: memory write data.
- `mem_ack` in 1: memory accepts the access this cycle. Read data is valid in the same cycle.
- `mem_rdata` in DATA_W: memory read data.
- `stall` out 1: pipeline stall request.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the side not granted last (`last_owner`).
  - On grant, latch `owner`, the line base (requester address with its low BW+2 bits zeroed), and `we` (`d_we` for D-side, 0 for I-side). Clear the beat counter. Go to ISSUE.
- ISSUE:
  - `mem_req`=1.
  - `mem_addr` = line base + (beat << 2), with modulo-2^ADDR_W wrap.
  - `mem_we` = latched `we`.
  - `mem_wdata` = `d_wdata`, combinational pass-through. The D-side must drive the word for index `beat`.
  - Address and data are held stable until `mem_ack`.
  - On `mem_ack` for a read: register `mem_rdata` into `rdata`. Pulse the owner's `*_rvalid` next cycle, with `beat` equal to the acked index.
  - On `mem_ack` at beat = LINE_WORDS-1: go to DONE. Otherwise increment the beat counter.
- DONE:
  - Pulse the owner's `*_done` for one cycle.
  - Update `last_owner` to `owner`.
  - Return to IDLE. Requests are not sampled in DONE.
- `stall` = (`i_req` & ~`i_done`) | (`d_req` & ~`d_done`), combinational.
- A request dropped mid-burst is a protocol violation. The burst still completes and `done` still pulses.
- Address or `d_we` changes after grant are ignored.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - state IDLE, beat counter 0, `last_owner` = 0, so the D-side wins the first conflict;
  - outputs `mem_req`, `mem_we`, `i_rvalid`, `d_rvalid`, `i_done`, `d_done`, `busy`, `owner` = 0;
  - `rdata` = 0, `mem_addr` = 0.
- Reset mid-burst aborts immediately. `mem_req` falls asynchronously.
- Request to first `mem_req`: 1 cycle (grant is registered).
- With `mem_ack` tied high, a request seen in IDLE at cycle 0 gives:
  - beats issued at cycles 1..LINE_WORDS;
  - `rvalid` for beat k at cycle k+2;
  - `done` at cycle LINE_WORDS+1, coinciding with the last `rvalid`;
  - next grant possible at cycle LINE_WORDS+2.
- Each cycle with `mem_ack`=0 in ISSUE adds one cycle of latency with no state change.
- Write-back bursts never assert `rvalid`.
- `*_rvalid` and `*_done` are never asserted for the non-owner.

## Test plan
- Reset: hold `reset`=0 with both requests high. All outputs are 0 and `mem_req`=0. On release with `d_req`=1 and `i_req`=1, the first grant is D.
- I refill, LINE_WORDS=4, `i_addr`=0x0000_1234, `mem_ack`=1, `mem_rdata`=addr:
  - `mem_addr` = 0x1230, 0x1234, 0x1238, 0x123C;
  - `i_rvalid` with `rdata` = 0x1230..0x123C at cycles 2..5;
  - `i_done` at cycle 5.
- D write-back, `d_addr`=0x8000_0010, `d_we`=1, `d_wdata`=0xA0+beat, `mem_ack` low for 2 cycles on beat 1:
  - `mem_we`=1, `mem_wdata` = 0xA0..0xA3 at 0x8000_0010..0x8000_001C;
  - beat 1 held 3 cycles; no `d_rvalid`; `d_done` after 6 cycles of ISSUE.
- Conflict: `i_req` and `d_req` high simultaneously and continuously.
  - Grants alternate D, I, D, I.
  - `stall` stays 1 until the final `*_done` cycle.
- Wrap: `d_addr`=0xFFFF_FFFC refill. The line base is 0xFFFF_FFF0 and `mem_addr` never exceeds 0xFFFF_FFFC.
- Async reset asserted in the middle of beat 2 of an I refill: `mem_req` drops within the same cycle. After release, a fresh `i_req` restarts at beat 0.
